// File: rtl/in_pio_irq_if.sv
// Avalon-MM slave bus bundle for the input PIO: word address, select,
// active-low write strobe, write data and registered read data.
interface in_pio_irq_if #(
  parameter int WIDTH = 8
);
  logic [1:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [WIDTH-1:0] writedata;
  logic [WIDTH-1:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/in_pio_irq.sv
// Input PIO for switches/buttons: two-flop synchroniser, optional per-bit
// debounce, sticky edge capture (W1C) and a maskable level interrupt.
module in_pio_irq #(
  parameter int WIDTH           = 8,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  in_pio_irq_if.slave       bus,
  input  logic [WIDTH-1:0]  in_port,
  output logic              irq
);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] deb;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] edge_sel;
  logic [WIDTH-1:0] clr;
  logic             wr_en;

  function automatic logic [WIDTH-1:0] edge_pick(input logic [WIDTH-1:0] cur,
                                                 input logic [WIDTH-1:0] old);
    case (EDGE_TYPE)
      1:       return ~cur & old;
      2:       return cur ^ old;
      default: return cur & ~old;
    endcase
  endfunction

  // Synchroniser stage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

  // Debounce stage: deb follows sync2 only after D consecutive disagreeing cycles
  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_nodeb
      assign deb = sync2;
    end else begin : g_deb
      localparam logic [15:0] DEB_LAST = 16'(DEBOUNCE_CYCLES - 1);
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [15:0] cnt;
        logic        deb_bit;
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            cnt     <= '0;
            deb_bit <= 1'b0;
          end else if (sync2[i] == deb_bit) begin
            cnt <= '0;
          end else if (cnt == DEB_LAST) begin
            cnt     <= '0;
            deb_bit <= sync2[i];
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        assign deb[i] = deb_bit;
      end
    end
  endgenerate

  assign edge_sel = edge_pick(deb, prev);
  assign wr_en    = bus.chipselect & ~bus.write_n;
  assign clr      = (wr_en && bus.address == 2'd3) ? bus.writedata : '0;

  // Edge capture and register stage; a new edge beats a same-cycle clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev         <= '0;
      irq_mask     <= '0;
      edge_cap     <= '0;
      bus.readdata <= '0;
    end else begin
      prev     <= deb;
      edge_cap <= (edge_cap & ~clr) | edge_sel;
      if (wr_en && bus.address == 2'd2) irq_mask <= bus.writedata;
      case (bus.address)
        2'd0:    bus.readdata <= deb;
        2'd2:    bus.readdata <= irq_mask;
        2'd3:    bus.readdata <= edge_cap;
        default: bus.readdata <= '0;
      endcase
    end
  end

  assign irq = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_in_pio_irq.sv
// Bench for in_pio_irq: four instances (rising/D=0, rising/D=4, falling, any)
// share one bus; register reads are checked through an expected-value queue.
module tb_in_pio_irq;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] address;
  logic       cs;
  logic       wn;
  logic [7:0] wd;
  logic [7:0] pin [4];
  logic [7:0] rd  [4];
  logic [3:0] irq_v;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  in_pio_irq_if #(.WIDTH(8)) b0 ();
  in_pio_irq_if #(.WIDTH(8)) b1 ();
  in_pio_irq_if #(.WIDTH(8)) b2 ();
  in_pio_irq_if #(.WIDTH(8)) b3 ();

  assign b0.address = address; assign b0.chipselect = cs; assign b0.write_n = wn; assign b0.writedata = wd;
  assign b1.address = address; assign b1.chipselect = cs; assign b1.write_n = wn; assign b1.writedata = wd;
  assign b2.address = address; assign b2.chipselect = cs; assign b2.write_n = wn; assign b2.writedata = wd;
  assign b3.address = address; assign b3.chipselect = cs; assign b3.write_n = wn; assign b3.writedata = wd;
  assign rd[0] = b0.readdata;
  assign rd[1] = b1.readdata;
  assign rd[2] = b2.readdata;
  assign rd[3] = b3.readdata;

  in_pio_irq #(.WIDTH(8), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(0)) u0 (
    .clk(clk), .reset_n(reset_n), .bus(b0.slave), .in_port(pin[0]), .irq(irq_v[0]));
  in_pio_irq #(.WIDTH(8), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(4)) u1 (
    .clk(clk), .reset_n(reset_n), .bus(b1.slave), .in_port(pin[1]), .irq(irq_v[1]));
  in_pio_irq #(.WIDTH(8), .EDGE_TYPE(1), .DEBOUNCE_CYCLES(0)) u2 (
    .clk(clk), .reset_n(reset_n), .bus(b2.slave), .in_port(pin[2]), .irq(irq_v[2]));
  in_pio_irq #(.WIDTH(8), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(0)) u3 (
    .clk(clk), .reset_n(reset_n), .bus(b3.slave), .in_port(pin[3]), .irq(irq_v[3]));

  typedef struct {
    int         inst;
    logic [1:0] addr;
    logic [7:0] rdata;
    logic       irq;
  } vec_t;

  typedef struct {
    int         inst;
    logic [7:0] exp;
    string      name;
  } sb_t;

  vec_t rst_tab    [8];
  vec_t settle_tab [10];
  sb_t  sb_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd_chk(input int inst, input logic [1:0] a, input logic [7:0] exp, input string name);
    sb_t e;
    address = a;
    e.inst  = inst;
    e.exp   = exp;
    e.name  = name;
    sb_q.push_back(e);
    step(1);
    e = sb_q.pop_front();
    chk(e.name, {24'd0, rd[e.inst]}, {24'd0, e.exp});
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    address = a;
    wd      = d;
    cs      = 1'b1;
    wn      = 1'b0;
    step(1);
    cs      = 1'b0;
    wn      = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) rst_tab[i] = '{i / 4, 2'(i % 4), 8'h00, 1'b0};
    settle_tab[0] = '{0, 2'd0, 8'hA5, 1'b0};
    settle_tab[1] = '{0, 2'd3, 8'hA5, 1'b0};
    settle_tab[2] = '{0, 2'd1, 8'h00, 1'b0};
    settle_tab[3] = '{0, 2'd2, 8'h00, 1'b0};
    settle_tab[4] = '{1, 2'd0, 8'hA5, 1'b0};
    settle_tab[5] = '{1, 2'd3, 8'hA5, 1'b0};
    settle_tab[6] = '{2, 2'd0, 8'hA5, 1'b0};
    settle_tab[7] = '{2, 2'd3, 8'h00, 1'b0};
    settle_tab[8] = '{3, 2'd0, 8'hA5, 1'b0};
    settle_tab[9] = '{3, 2'd3, 8'hA5, 1'b0};

    reset_n = 1'b0;
    address = 2'd0;
    cs      = 1'b0;
    wn      = 1'b1;
    wd      = 8'h00;
    for (int i = 0; i < 4; i++) pin[i] = 8'hA5;
    step(2);

    // Held in reset: every register reads zero, no interrupt
    for (int i = 0; i < 8; i++) begin
      rd_chk(rst_tab[i].inst, rst_tab[i].addr, rst_tab[i].rdata, $sformatf("rst_rd_%0d", i));
      chk($sformatf("rst_irq_%0d", i), {31'd0, irq_v[rst_tab[i].inst]}, {31'd0, rst_tab[i].irq});
    end

    // Release: DATA shows the input on the third edge for D=0
    address = 2'd0;
    reset_n = 1'b1;
    step(2);
    chk("rel_data_e2", {24'd0, rd[0]}, 32'h00);
    step(1);
    chk("rel_data_e3", {24'd0, rd[0]}, 32'hA5);
    chk("rel_deb_e3", {24'd0, rd[1]}, 32'h00);
    step(10);
    for (int i = 0; i < 10; i++) begin
      rd_chk(settle_tab[i].inst, settle_tab[i].addr, settle_tab[i].rdata, $sformatf("settle_rd_%0d", i));
      chk($sformatf("settle_irq_%0d", i), {31'd0, irq_v[settle_tab[i].inst]}, {31'd0, settle_tab[i].irq});
    end

    // W1C and masking
    for (int i = 0; i < 4; i++) pin[i] = 8'h00;
    step(12);
    wr(2'd3, 8'hFF);
    wr(2'd2, 8'h01);
    chk("irq_all_clear", {28'd0, irq_v}, 32'h0);
    pin[0] = 8'h01;
    step(2);
    chk("w1c_irq_early", {31'd0, irq_v[0]}, 32'd0);
    step(1);
    chk("w1c_irq_rise", {31'd0, irq_v[0]}, 32'd1);
    rd_chk(0, 2'd3, 8'h01, "w1c_cap");
    wr(2'd3, 8'h01);
    chk("w1c_irq_fall", {31'd0, irq_v[0]}, 32'd0);
    rd_chk(0, 2'd3, 8'h00, "w1c_cap_clr");
    pin[0] = 8'h11;
    step(4);
    chk("mask_bit4_irq", {31'd0, irq_v[0]}, 32'd0);
    rd_chk(0, 2'd3, 8'h10, "mask_bit4_cap");

    // Debounce D=4: 3-cycle glitch rejected, 4-cycle level accepted
    pin[1] = 8'h04;
    step(3);
    pin[1] = 8'h00;
    step(8);
    rd_chk(1, 2'd0, 8'h00, "deb_glitch_data");
    rd_chk(1, 2'd3, 8'h00, "deb_glitch_cap");
    address = 2'd0;
    pin[1]  = 8'h04;
    step(6);
    chk("deb_data_k5", {24'd0, rd[1]}, 32'h00);
    step(1);
    chk("deb_data_k6", {24'd0, rd[1]}, 32'h04);
    rd_chk(1, 2'd3, 8'h04, "deb_cap");

    // Falling and any-edge capture of a bit7 pulse
    wr(2'd3, 8'hFF);
    pin[2] = 8'h80;
    pin[3] = 8'h80;
    step(4);
    rd_chk(2, 2'd3, 8'h00, "fall_rise_ignored");
    rd_chk(3, 2'd3, 8'h80, "any_first");
    pin[2] = 8'h00;
    pin[3] = 8'h00;
    step(4);
    rd_chk(2, 2'd3, 8'h80, "fall_capture");
    rd_chk(3, 2'd3, 8'h80, "any_sticky");

    // Clear and new edge on the same bit in the same cycle
    wr(2'd3, 8'hFF);
    wr(2'd2, 8'h08);
    chk("sim_irq_pre", {31'd0, irq_v[0]}, 32'd0);
    pin[0] = 8'h08;
    step(3);
    chk("sim_irq_first", {31'd0, irq_v[0]}, 32'd1);
    pin[0] = 8'h00;
    step(4);
    pin[0] = 8'h08;
    step(2);
    wr(2'd3, 8'h08);
    chk("sim_irq_hold", {31'd0, irq_v[0]}, 32'd1);
    rd_chk(0, 2'd3, 8'h08, "sim_cap_hold");
    wr(2'd3, 8'h08);
    chk("sim_irq_clear", {31'd0, irq_v[0]}, 32'd0);

    // Reset in the middle of a debounce count
    pin[1] = 8'h00;
    step(10);
    pin[1] = 8'h04;
    step(4);
    reset_n = 1'b0;
    step(2);
    chk("mid_rst_irq", {28'd0, irq_v}, 32'h0);
    rd_chk(1, 2'd0, 8'h00, "mid_rst_data");
    rd_chk(0, 2'd2, 8'h00, "mid_rst_mask");
    address = 2'd0;
    reset_n = 1'b1;
    step(6);
    chk("mid_rst_k6", {24'd0, rd[1]}, 32'h00);
    step(1);
    chk("mid_rst_k7", {24'd0, rd[1]}, 32'h04);
    rd_chk(0, 2'd2, 8'h00, "post_rst_mask");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/in_pio_irq.md
# in_pio_irq

Parametrised Avalon-MM input PIO slave for board switches and push-buttons, successor to the fixed 8-bit read-only switch port. It adds configurable width, a two-flop input synchroniser, optional per-bit debounce, edge capture with write-1-to-clear, and a maskable level interrupt. It sits on the Nios II system interconnect alongside the existing PIOs.

## Interface
- WIDTH, 8, number of input bits (1..32)
- EDGE_TYPE, 0, edge captured: 0 = rising, 1 = falling, 2 = any
- DEBOUNCE_CYCLES, 0, consecutive stable cycles required per bit (0 = debounce bypassed; max 65535)
- clk  input  1  system clock
- reset_n  input  1  reset, asynchronous, active-low
- address  input  2  word address of register
- chipselect  input  1  slave select
- write_n  input  1  active-low write strobe
- writedata  input  WIDTH  write data
- readdata  output  WIDTH  registered read data
- in_port  input  WIDTH  asynchronous external inputs
- irq  output  1  level interrupt to CPU

## Operation
- Register map:
  - 0: DATA (RO), debounced input value.
  - 1: reserved, reads 0, writes ignored.
  - 2: IRQ_MASK (RW), per-bit interrupt enable.
  - 3: EDGE_CAP (R/W1C), per-bit sticky edge flags.
- Write occurs when chipselect=1 and write_n=0. Writes to addresses 0 and 1 have no effect.
- Synchroniser: sync1 <= in_port; sync2 <= sync1, per bit.
- Debounce, per bit, when DEBOUNCE_CYCLES=D>0:
  - A 16-bit counter increments each cycle sync2 != deb.
  - The counter clears each cycle sync2 == deb.
  - On the D-th consecutive disagreeing cycle, deb <= sync2 and the counter clears.
  - A glitch shorter than D cycles never changes deb.
- When D=0, deb = sync2 (no extra register).
- Edge detect: prev <= deb each cycle.
  - rising = deb & ~prev
  - falling = ~deb & prev
  - any = deb ^ prev
  - The selected edge vector ORs into EDGE_CAP.
- EDGE_CAP write: bits set in writedata clear. A new edge on the same bit in the same cycle wins: the bit stays 1.
- irq = |(EDGE_CAP & IRQ_MASK), combinational from registers, no extra latency.
- readdata <= mux(address) every cycle, independent of chipselect; read latency 1.
- Reset values (all 0):
  - sync1, sync2, deb, prev, all counters.
  - IRQ_MASK, EDGE_CAP.
  - readdata, irq.
- An input held high across reset deassertion produces one rising edge once it propagates. This is intended behaviour; software clears EDGE_CAP at init.
- Reset asserted mid-debounce aborts the count; no partial state survives.

## Timing
- in_port changes before clk edge k: sync2 updates at edge k+1.
- deb updates at edge k+1+D.
- EDGE_CAP bit sets at edge k+2+D; irq rises in that cycle if masked in.
- DATA readable on readdata at edge k+2+D, with address=0 applied before that edge.
- A W1C write at edge n clears the bit at edge n. irq falls in the following cycle unless another edge sets the bit at edge n.
- An IRQ_MASK write at edge n affects irq from edge n.

## Test plan
- Reset:
  - Stimulus: hold reset_n=0 with in_port=0xA5, address=0..3, WIDTH=8, D=0.
  - Response: readdata=0x00 and irq=0 throughout.
  - After release: DATA reads 0xA5 by the 3rd cycle. EDGE_CAP reads 0xA5 (rising, EDGE_TYPE=0).
- W1C plus masking:
  - Stimulus: write EDGE_CAP=0xFF, set IRQ_MASK=0x01, toggle in_port bit0 0->1.
  - Response: EDGE_CAP=0x01 at k+2, irq=1. Write EDGE_CAP=0x01 drops irq the next cycle.
  - Stimulus: bit4 rising with IRQ_MASK=0x01.
  - Response: EDGE_CAP bit4 set, irq stays 0.
- Debounce, D=4:
  - Stimulus: 3-cycle pulse on bit2.
  - Response: DATA unchanged, EDGE_CAP=0.
  - Stimulus: 4-cycle-stable high on bit2.
  - Response: DATA bit2=1 at k+5, EDGE_CAP bit2 at k+6.
- EDGE_TYPE=1 and EDGE_TYPE=2:
  - Stimulus: pulse bit7 0->1->0.
  - Response: falling mode captures only the 1->0 transition. Any-edge mode sets bit7 on the first transition and keeps it sticky.
- Simultaneous set and clear:
  - Stimulus: W1C write of bit3 on the same edge that a new bit3 edge is captured.
  - Response: EDGE_CAP bit3 remains 1, irq stays asserted.
- Reset mid-operation:
  - Stimulus: assert reset_n during a D=4 debounce count at count 2, then release with in_port stable.
  - Response: all registers 0. The debounce restarts from 0 and needs 4 full cycles.
